// File: rtl/tag_tx_ctrl.sv
// Tag-side transmit controller: positive chirp, negative chirp, then constant-tone location slots as a phase stream.
// Define TAG_TX_GUARD_EN to follow every location slot with GUARD_LEN muted guard beats.
module tag_tx_ctrl #(
    parameter int PHASE_WIDTH   = 24,
    parameter int REG_WIDTH     = 12,
    parameter int NSYNCP        = 16384,
    parameter int NSYNCN        = 16384,
    parameter int NSIG          = 262144,
    parameter int NLOC_PER_SYNC = 3
`ifdef TAG_TX_GUARD_EN
    ,
    parameter int GUARD_LEN     = 64
`endif
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic                                       run_tx,
    input  logic [PHASE_WIDTH-1:0]                     chirp_step,
    input  logic [PHASE_WIDTH-1:0]                     loc_freq_base,
    input  logic [PHASE_WIDTH-1:0]                     loc_freq_step,
    output logic [PHASE_WIDTH-1:0]                     ph_tdata,
    output logic                                       ph_tvalid,
    input  logic                                       ph_tready,
    output logic [1:0]                                 tx_state,
    output logic                                       tx_sig,
    output logic [$clog2(NSYNCP+NSYNCN+1)-1:0]         nsync_count,
    output logic [$clog2(NSIG+1)-1:0]                  sigN,
    output logic [$clog2(NLOC_PER_SYNC+1)-1:0]         locN,
    output logic                                       tx_trig,
    output logic                                       tx_mute,
    output logic                                       frame_done,
    output logic [REG_WIDTH-1:0]                       fp_gpio_out,
    output logic [REG_WIDTH-1:0]                       fp_gpio_ddr
);
    localparam int NSYNC_W = $clog2(NSYNCP + NSYNCN + 1);
    localparam int SIG_W   = $clog2(NSIG + 1);
    localparam int LOC_W   = $clog2(NLOC_PER_SYNC + 1);

`ifdef TAG_TX_GUARD_EN
    localparam int GUARD_W = $clog2(GUARD_LEN + 1);
    typedef enum logic [2:0] {ST_IDLE, ST_SYNC_P, ST_SYNC_N, ST_SIG, ST_GUARD} state_t;
    logic [GUARD_W-1:0] guard_q, guard_d;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_SYNC_P, ST_SYNC_N, ST_SIG} state_t;
`endif

    state_t                 state_q, state_d;
    logic [PHASE_WIDTH-1:0] ph_q, ph_d;
    logic [PHASE_WIDTH-1:0] fw_q, fw_d;
    logic [NSYNC_W-1:0]     nsync_q, nsync_d;
    logic [SIG_W-1:0]       sig_q, sig_d;
    logic [LOC_W-1:0]       loc_q, loc_d;
    logic                   trig_q;
    logic [REG_WIDTH-1:0]   ddr_q;
    logic                   accept;
    logic                   slot_done;
    logic                   frame_end;

    assign accept = ph_tvalid && ph_tready;

    // NOTE: every signal driven here gets a default before the case, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        fw_d      = fw_q;
        nsync_d   = nsync_q;
        sig_d     = sig_q;
        loc_d     = loc_q;
`ifdef TAG_TX_GUARD_EN
        guard_d   = guard_q;
`endif
        slot_done = 1'b0;
        frame_end = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run_tx) state_d = ST_SYNC_P;
            end
            ST_SYNC_P: begin
                if (accept) begin
                    ph_d    = ph_q + fw_q;
                    nsync_d = nsync_q + 1'b1;
                    if (nsync_q == NSYNC_W'(NSYNCP - 1)) begin
                        fw_d    = '0;
                        state_d = ST_SYNC_N;
                    end else begin
                        fw_d = fw_q + chirp_step;
                    end
                end
            end
            ST_SYNC_N: begin
                if (accept) begin
                    ph_d = ph_q + fw_q;
                    if (nsync_q == NSYNC_W'(NSYNCP + NSYNCN - 1)) begin
                        fw_d    = loc_freq_base;
                        sig_d   = '0;
                        loc_d   = '0;
                        state_d = ST_SIG;
                    end else begin
                        fw_d    = fw_q - chirp_step;
                        nsync_d = nsync_q + 1'b1;
                    end
                end
            end
            ST_SIG: begin
                if (accept) begin
                    ph_d = ph_q + fw_q;
                    if (sig_q == SIG_W'(NSIG - 1)) begin
`ifdef TAG_TX_GUARD_EN
                        guard_d = '0;
                        state_d = ST_GUARD;
`else
                        slot_done = 1'b1;
`endif
                    end else begin
                        sig_d = sig_q + 1'b1;
                    end
                end
            end
`ifdef TAG_TX_GUARD_EN
            // Phase and frequency stay frozen; the slot advance is applied on the last guard beat.
            ST_GUARD: begin
                if (accept) begin
                    if (guard_q == GUARD_W'(GUARD_LEN - 1)) slot_done = 1'b1;
                    else guard_d = guard_q + 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (slot_done) begin
            if (loc_q == LOC_W'(NLOC_PER_SYNC - 1)) begin
                // End of frame: either restart a fresh frame or park in IDLE with everything cleared.
                frame_end = 1'b1;
                state_d   = run_tx ? ST_SYNC_P : ST_IDLE;
                ph_d      = '0;
                fw_d      = '0;
                nsync_d   = '0;
                sig_d     = '0;
                loc_d     = '0;
            end else begin
                fw_d    = fw_q + loc_freq_step;
                loc_d   = loc_q + 1'b1;
                sig_d   = '0;
                state_d = ST_SIG;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            ph_q    <= '0;
            fw_q    <= '0;
            nsync_q <= '0;
            sig_q   <= '0;
            loc_q   <= '0;
`ifdef TAG_TX_GUARD_EN
            guard_q <= '0;
`endif
            trig_q  <= 1'b0;
            ddr_q   <= '0;
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
            fw_q    <= fw_d;
            nsync_q <= nsync_d;
            sig_q   <= sig_d;
            loc_q   <= loc_d;
`ifdef TAG_TX_GUARD_EN
            guard_q <= guard_d;
`endif
            trig_q  <= accept && (state_q == ST_SYNC_P) && (nsync_q == '0);
            ddr_q   <= '1;
        end
    end

    always_comb begin
        tx_state = 2'd0;
        case (state_q)
            ST_SYNC_P:         tx_state = 2'd1;
            ST_SYNC_N, ST_SIG: tx_state = 2'd2;
`ifdef TAG_TX_GUARD_EN
            ST_GUARD:          tx_state = 2'd3;
`endif
            default:           tx_state = 2'd0;
        endcase
    end

`ifdef TAG_TX_GUARD_EN
    assign tx_mute  = (state_q == ST_GUARD);
`else
    assign tx_mute  = 1'b0;
`endif
    assign ph_tdata    = tx_mute ? '0 : ph_q;
    assign ph_tvalid   = (state_q != ST_IDLE);
    assign tx_sig      = (state_q == ST_SIG);
    assign nsync_count = nsync_q;
    assign sigN        = sig_q;
    assign locN        = loc_q;
    assign tx_trig     = trig_q;
    assign frame_done  = frame_end;
    assign fp_gpio_out = {{(REG_WIDTH-3){1'b0}}, trig_q,
                          (state_q == ST_SYNC_P) || (state_q == ST_SYNC_N), ph_tvalid};
    assign fp_gpio_ddr = ddr_q;

endmodule

// File: tb/tb_tag_tx_ctrl.sv
// Self-checking bench for tag_tx_ctrl: random frames against a closed-form phase model of the frame.
`timescale 1ns/1ps
module tb_tag_tx_ctrl;
    localparam int PW = 24, RW = 12, NP = 4, NN = 4, NS = 8, NL = 3;
`ifdef TAG_TX_GUARD_EN
    localparam int GL = 2;
`else
    localparam int GL = 0;
`endif
    localparam int FRAME_LEN = NP + NN + NL * (NS + GL);
    localparam int NSW = $clog2(NP + NN + 1);
    localparam int SGW = $clog2(NS + 1);
    localparam int LCW = $clog2(NL + 1);

    typedef enum int {K_SYNC_P, K_SYNC_N, K_SIG, K_GUARD} kind_e;
    typedef struct {
        logic [PW-1:0] ph;
        kind_e         kind;
        int            idx;
        int            loc;
        bit            first;
        bit            last;
    } beat_t;

    beat_t         exp_q[$];
    logic [PW-1:0] got_q[$];
    int tests = 0, fails = 0, trig_seen = 0, done_seen = 0;

    logic          clk = 1'b0;
    logic          reset, run_tx, ph_tready;
    logic [PW-1:0] chirp_step, loc_freq_base, loc_freq_step, ph_tdata;
    logic          ph_tvalid, tx_sig, tx_trig, tx_mute, frame_done;
    logic [1:0]    tx_state;
    logic [NSW-1:0] nsync_count;
    logic [SGW-1:0] sigN;
    logic [LCW-1:0] locN;
    logic [RW-1:0]  fp_gpio_out, fp_gpio_ddr;

    always #5 clk = ~clk;

    tag_tx_ctrl #(
        .PHASE_WIDTH(PW), .REG_WIDTH(RW), .NSYNCP(NP), .NSYNCN(NN), .NSIG(NS), .NLOC_PER_SYNC(NL)
`ifdef TAG_TX_GUARD_EN
        , .GUARD_LEN(GL)
`endif
    ) dut (
        .clk(clk), .reset(reset), .run_tx(run_tx), .chirp_step(chirp_step),
        .loc_freq_base(loc_freq_base), .loc_freq_step(loc_freq_step),
        .ph_tdata(ph_tdata), .ph_tvalid(ph_tvalid), .ph_tready(ph_tready),
        .tx_state(tx_state), .tx_sig(tx_sig), .nsync_count(nsync_count), .sigN(sigN), .locN(locN),
        .tx_trig(tx_trig), .tx_mute(tx_mute), .frame_done(frame_done),
        .fp_gpio_out(fp_gpio_out), .fp_gpio_ddr(fp_gpio_ddr)
    );

    function automatic longint tri_num(input int k);
        return longint'(k) * longint'(k - 1) / 2;
    endfunction

    function automatic void push(input longint ph, input kind_e k, input int idx, input int loc,
                                 input bit first, input bit last);
        beat_t b;
        b.ph = PW'(ph); b.kind = k; b.idx = idx; b.loc = loc; b.first = first; b.last = last;
        exp_q.push_back(b);
    endfunction

    // Closed-form frame: chirp phase is a triangular sum of the step, tone phase is linear per slot.
    function automatic void build_frame(input logic [PW-1:0] cs, input logic [PW-1:0] base,
                                        input logic [PW-1:0] ls);
        longint c = longint'(cs), b = longint'(base), s = longint'(ls);
        longint p_end = c * tri_num(NP);
        longint start = p_end - c * tri_num(NN);
        longint fw;
        for (int k = 0; k < NP; k++) push(c * tri_num(k), K_SYNC_P, k, 0, k == 0, 1'b0);
        for (int k = 0; k < NN; k++) push(p_end - c * tri_num(k), K_SYNC_N, NP + k, 0, 1'b0, 1'b0);
        for (int l = 0; l < NL; l++) begin
            fw = b + longint'(l) * s;
            for (int i = 0; i < NS; i++)
                push(start + longint'(i) * fw, K_SIG, i, l, 1'b0, GL == 0 && l == NL - 1 && i == NS - 1);
            start += longint'(NS) * fw;
            for (int g = 0; g < GL; g++) push(0, K_GUARD, g, l, 1'b0, l == NL - 1 && g == GL - 1);
        end
    endfunction

    task automatic stream(input int ready_pct, input int stall_at, input int stall_len,
                          input int drop_at, input int stop_after);
        int consumed = 0, stalled = 0, cyc = 0;
        bit trig_exp = 1'b0, trig_next;
        beat_t e;
        logic [1:0] st_exp;
        logic [RW-1:0] gpio_exp;
        while (exp_q.size() > 0 && (stop_after < 0 || consumed < stop_after)) begin
            @(negedge clk);
            if (consumed >= drop_at) run_tx = 1'b0;
            if (consumed == stall_at && stalled < stall_len) begin
                ph_tready = 1'b0;
                stalled++;
            end else begin
                ph_tready = (int'($urandom_range(0, 99)) < ready_pct);
            end
            #1;
            trig_next = 1'b0;
            tests++;
            if (tx_trig !== trig_exp) begin
                fails++;
                $display("FAIL tx_trig beat=%0d got=%b exp=%b", consumed, tx_trig, trig_exp);
            end
            if (tx_trig === 1'b1) trig_seen++;
            if (frame_done === 1'b1) done_seen++;
            tests++;
            if (ph_tvalid !== 1'b1) begin
                fails++;
                $display("FAIL ph_tvalid beat=%0d got=%b exp=1", consumed, ph_tvalid);
                exp_q.delete();
            end else begin
                e = exp_q[0];
                case (e.kind)
                    K_SYNC_P: st_exp = 2'd1;
                    K_GUARD:  st_exp = 2'd3;
                    default:  st_exp = 2'd2;
                endcase
                tests++;
                if ({ph_tdata, tx_state, tx_sig, tx_mute, frame_done} !==
                    {e.ph, st_exp, e.kind == K_SIG, e.kind == K_GUARD, e.last && ph_tready}) begin
                    fails++;
                    $display("FAIL beat=%0d got ph=%0d st=%0d sig=%b mute=%b done=%b exp ph=%0d st=%0d sig=%b mute=%b done=%b",
                             consumed, ph_tdata, tx_state, tx_sig, tx_mute, frame_done,
                             e.ph, st_exp, e.kind == K_SIG, e.kind == K_GUARD, e.last && ph_tready);
                end
                gpio_exp    = '0;
                gpio_exp[0] = 1'b1;
                gpio_exp[1] = (e.kind == K_SYNC_P || e.kind == K_SYNC_N);
                gpio_exp[2] = trig_exp;
                tests++;
                if (fp_gpio_out !== gpio_exp) begin
                    fails++;
                    $display("FAIL gpio beat=%0d got=%h exp=%h", consumed, fp_gpio_out, gpio_exp);
                end
                tests++;
                if (e.kind == K_SIG) begin
                    if ({sigN, locN} !== {SGW'(e.idx), LCW'(e.loc)}) begin
                        fails++;
                        $display("FAIL slot_ctr beat=%0d got sigN=%0d locN=%0d exp %0d %0d",
                                 consumed, sigN, locN, e.idx, e.loc);
                    end
                end else if (e.kind == K_GUARD) begin
                    if (locN !== LCW'(e.loc)) begin
                        fails++;
                        $display("FAIL guard_loc beat=%0d got=%0d exp=%0d", consumed, locN, e.loc);
                    end
                end else if ({nsync_count, sigN, locN} !== {NSW'(e.idx), SGW'(0), LCW'(0)}) begin
                    fails++;
                    $display("FAIL sync_ctr beat=%0d got nsync=%0d sigN=%0d locN=%0d exp %0d 0 0",
                             consumed, nsync_count, sigN, locN, e.idx);
                end
                if (ph_tready) begin
                    got_q.push_back(ph_tdata);
                    void'(exp_q.pop_front());
                    consumed++;
                    trig_next = e.first;
                end
            end
            trig_exp = trig_next;
            cyc++;
            if (cyc > 4000 && exp_q.size() > 0) begin
                tests++;
                fails++;
                $display("FAIL stream_timeout consumed=%0d pending=%0d", consumed, exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    task automatic expect_idle();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            tests++;
            if ({ph_tvalid, tx_state, tx_sig, nsync_count, sigN, locN, frame_done, fp_gpio_out[1:0]} !== '0) begin
                fails++;
                $display("FAIL idle got valid=%b st=%0d nsync=%0d sigN=%0d locN=%0d done=%b",
                         ph_tvalid, tx_state, nsync_count, sigN, locN, frame_done);
            end
        end
    endtask

    task automatic launch(input logic [PW-1:0] cs, input logic [PW-1:0] base,
                          input logic [PW-1:0] ls, input int nframes);
        got_q.delete();
        exp_q.delete();
        trig_seen = 0;
        done_seen = 0;
        for (int f = 0; f < nframes; f++) build_frame(cs, base, ls);
        @(negedge clk);
        chirp_step = cs; loc_freq_base = base; loc_freq_step = ls;
        run_tx = 1'b1;
    endtask

    task automatic check_val(input string name, input longint got, input longint exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; run_tx = 1'b0; ph_tready = 1'b0;
        chirp_step = '0; loc_freq_base = '0; loc_freq_step = '0;
        #1;
        tests++;
        if ({ph_tdata, ph_tvalid, tx_state, tx_sig, tx_trig, tx_mute, frame_done, fp_gpio_out, fp_gpio_ddr} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got ph=%0d valid=%b gpio=%h ddr=%h", ph_tdata, ph_tvalid, fp_gpio_out, fp_gpio_ddr);
        end
        run_tx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("reset_holds_idle", ph_tvalid, 0);
        @(negedge clk);
        run_tx = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        #1;
        check_val("ddr_after_reset", fp_gpio_ddr, (1 << RW) - 1);
        expect_idle();
    endtask

    task automatic test_single_frame();
        launch(24'd1, 24'd16, 24'd8, 1);
        stream(100, -1, 0, 0, -1);
        check_val("frame_beats", got_q.size(), FRAME_LEN);
        if (got_q.size() == FRAME_LEN) begin
            check_val("sync_n_first_ph", got_q[NP], 6);
            check_val("slot0_beat1_ph", got_q[NP + NN + 1], 16);
            check_val("slot1_first_ph", got_q[NP + NN + NS + GL], 128);
            check_val("slot2_last_ph", got_q[FRAME_LEN - 1 - GL], 544);
`ifdef TAG_TX_GUARD_EN
            check_val("guard_ph_zero", got_q[NP + NN + NS], 0);
`endif
        end
        check_val("single_done_count", done_seen, 1);
        check_val("single_trig_count", trig_seen, 1);
        expect_idle();
    endtask

    task automatic test_backpressure();
        launch(24'd1, 24'd16, 24'd8, 1);
        stream(100, NP + 1, 5, 0, -1);
        check_val("bp_frame_beats", got_q.size(), FRAME_LEN);
        check_val("bp_done_count", done_seen, 1);
        expect_idle();
    endtask

    task automatic test_back_to_back();
        launch(24'd1, 24'd16, 24'd8, 2);
        stream(70, -1, 0, FRAME_LEN + 3, -1);
        check_val("b2b_beats", got_q.size(), 2 * FRAME_LEN);
        if (got_q.size() > FRAME_LEN) check_val("b2b_restart_ph", got_q[FRAME_LEN], 0);
        check_val("b2b_trig_count", trig_seen, 2);
        check_val("b2b_done_count", done_seen, 2);
        expect_idle();
    endtask

    task automatic test_random();
        int nf;
        for (int it = 0; it < 6; it++) begin
            nf = int'($urandom_range(1, 2));
            launch(PW'($urandom()), PW'($urandom()), PW'($urandom()), nf);
            stream(int'($urandom_range(30, 100)), int'($urandom_range(0, FRAME_LEN - 1)),
                   int'($urandom_range(0, 4)),
                   int'($urandom_range((nf - 1) * FRAME_LEN, nf * FRAME_LEN - 1)), -1);
            check_val("rand_done_count", done_seen, nf);
            expect_idle();
        end
    endtask

    task automatic test_async_reset();
        launch(24'd1, 24'd16, 24'd8, 1);
        stream(100, -1, 0, 1 << 20, NP + NN + 3);
        @(posedge clk);
        #2;
        check_val("pre_abort_sigN", sigN, 3);
        reset = 1'b0;
        #1;
        tests++;
        if ({ph_tdata, ph_tvalid, tx_state, tx_sig, nsync_count, sigN, locN, tx_trig, tx_mute,
             frame_done, fp_gpio_out, fp_gpio_ddr} !== '0) begin
            fails++;
            $display("FAIL async_reset got ph=%0d valid=%b st=%0d sigN=%0d locN=%0d ddr=%h",
                     ph_tdata, ph_tvalid, tx_state, sigN, locN, fp_gpio_ddr);
        end
        exp_q.delete();
        got_q.delete();
        done_seen = 0;
        build_frame(24'd1, 24'd16, 24'd8);
        @(negedge clk);
        reset = 1'b1;
        stream(100, -1, 0, 0, -1);
        check_val("restart_beats", got_q.size(), FRAME_LEN);
        if (got_q.size() > 0) check_val("restart_first_ph", got_q[0], 0);
        check_val("restart_done_count", done_seen, 1);
        expect_idle();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tag_tx_ctrl.md
Name: tag_tx_ctrl

Overview:
Tag-side transmit controller; the transmit end of the sync/location waveform that tag_rx_ctrl detects. On run_tx it emits one frame of phase samples: a positive-slope chirp, a negative-slope chirp, then NLOC_PER_SYNC constant-tone location slots of NSIG samples each. The phase stream feeds a downstream DDS over a valid/ready handshake. It also drives front-panel GPIO status/trigger bits.

Parameters:
PHASE_WIDTH, 24, width of the phase accumulator, frequency word and ph_tdata
REG_WIDTH, 12, front-panel GPIO width
NSYNCP, 16384, beats in the positive chirp
NSYNCN, 16384, beats in the negative chirp
NSIG, 262144, beats per location slot
NLOC_PER_SYNC, 3, location slots per frame
GUARD_LEN, 64, guard beats after each slot (used only with TAG_TX_GUARD_EN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
run_tx  in  1  level request to transmit frames
chirp_step  in  PHASE_WIDTH  frequency-word delta per beat during sync
loc_freq_base  in  PHASE_WIDTH  frequency word of slot 0
loc_freq_step  in  PHASE_WIDTH  frequency-word increment per slot
ph_tdata  out  PHASE_WIDTH  phase sample to DDS
ph_tvalid  out  1  phase sample valid
ph_tready  in  1  DDS accepts sample
tx_state  out  2  0 IDLE, 1 SYNC_P, 2 SYNC_N/SIG (see tx_sig), 3 GUARD
tx_sig  out  1  1 while in SIG
nsync_count  out  clog2(NSYNCP+NSYNCN+1)  sync beat index
sigN  out  clog2(NSIG+1)  beat index within slot
locN  out  clog2(NLOC_PER_SYNC+1)  current slot
tx_trig  out  1  1-cycle pulse on first accepted SYNC_P beat
tx_mute  out  1  1 during guard beats
frame_done  out  1  1-cycle pulse on last accepted beat of a frame
fp_gpio_out  out  REG_WIDTH  bit0 ph_tvalid, bit1 in sync, bit2 tx_trig, others 0
fp_gpio_ddr  out  REG_WIDTH  all ones out of reset

Behaviour:
- Reset (async assert, sync release): all outputs 0, including fp_gpio_ddr; ph=0, fw=0; state IDLE.
- A beat is accepted when ph_tvalid && ph_tready. Without acceptance, ph_tdata, state, counters and fw all hold.
- IDLE: ph_tvalid=0. When run_tx=1 is sampled, the next cycle is SYNC_P with ph_tvalid=1, ph=0, fw=0. Latency is 1 clock.
- ph_tdata = ph (registered). Every accepted beat: ph <= ph + fw, modulo 2^PHASE_WIDTH.
- SYNC_P, NSYNCP beats, nsync_count 0..NSYNCP-1:
  - fw <= fw + chirp_step.
  - On the last beat: fw <= 0 and go to SYNC_N.
- SYNC_N, NSYNCN beats, nsync_count continues to NSYNCP+NSYNCN-1:
  - fw <= fw - chirp_step.
  - On the last beat: fw <= loc_freq_base, locN=0, go to SIG.
- SIG, NSIG beats per slot, sigN 0..NSIG-1, fw constant:
  - On the last beat of a slot that is not the final slot: fw <= fw + loc_freq_step, locN+1, sigN=0.
  - After the final slot: frame_done pulses.
  - If run_tx=1 on that beat: restart SYNC_P with ph<=0, fw<=0, counters cleared.
  - Otherwise: go to IDLE with ph_tvalid=0.
- Frames are atomic: deasserting run_tx mid-frame has no effect until the frame ends.
- Counters clear on entering IDLE.
- tx_trig pulses in the cycle after the first SYNC_P beat is accepted. It pulses once per frame.
- tx_state encoding: 2 with tx_sig=0 means SYNC_N; 2 with tx_sig=1 means SIG.
- Async reset mid-frame aborts the frame immediately. No frame_done is produced.

Optional Feature:
TAG_TX_GUARD_EN: after every location slot (including the last), insert GUARD state of GUARD_LEN accepted beats.
- During guard: tx_state=3, tx_mute=1, ph_tdata=0.
- ph and fw are frozen; the slot transition takes effect after the guard.
- frame_done moves to the last guard beat.
Without the macro: no GUARD state exists, tx_state never equals 3, and tx_mute is tied to 0.

Test Plan:
Common configuration: NSYNCP=4, NSYNCN=4, NSIG=8, NLOC_PER_SYNC=3, chirp_step=1, loc_freq_base=16, loc_freq_step=8.
1. Single frame, ph_tready=1, run_tx pulsed 1 cycle -> exactly 32 beats:
   - ph_tdata 0,0,1,3 (SYNC_P), then 6,6,5,3 (SYNC_N).
   - Slot0 0,16,...,112; slot1 128,152,...,296; slot2 320,352,...,544.
   - frame_done on beat 31, then ph_tvalid=0.
2. Backpressure: ph_tready=0 for 5 cycles at SYNC_N beat 1 -> ph_tdata stays 6, nsync_count stays 5; the sequence resumes unchanged.
3. run_tx held high -> beat 32 has ph_tdata=0, tx_state=1; tx_trig pulses twice across two frames; no IDLE gap.
4. reset driven low at SIG beat 3, asynchronously (between clock edges) -> all outputs 0 immediately; after release with run_tx=1, the frame restarts at ph_tdata=0.
5. PHASE_WIDTH=8, loc_freq_base=200 -> slot0 ph_tdata 0,200,144,88,... (mod 256).
6. TAG_TX_GUARD_EN, GUARD_LEN=2 -> 2 muted beats (ph_tdata=0, tx_state=3) after each slot; slot1 still starts at 128; 38 beats per frame.
